// File: rtl/fp_square_pkg.sv
// Shared definitions for the pipelined floating-point squarer: exception
// encodings, exponent bias and total-width helpers.
package fp_square_pkg;

    // Exception field of the {exc, sign, exp, frac} format.
    typedef enum logic [1:0] {
        EXC_ZERO = 2'b00,
        EXC_NORM = 2'b01,
        EXC_INF  = 2'b10,
        EXC_NAN  = 2'b11
    } exc_e;

    // Bits that sit around exp/frac in a packed word: exc (2) + sign (1).
    localparam int FP_EXTRA_W = 3;

    // Result classification produced by the final stage.
    typedef struct packed {
        exc_e exc;
        logic ovf;
        logic unf;
    } exc_map_t;

    function automatic int bias(input int we);
        return (1 << (we - 1)) - 1;
    endfunction

    function automatic int fp_width(input int we, input int wf);
        return we + wf + FP_EXTRA_W;
    endfunction

endpackage

// File: rtl/fp_square_pipe_if.sv
// Operand/result handshake bundle of the squarer. The slave side is the
// squarer itself, the master side is whoever feeds and drains it.
interface fp_square_pipe_if
    import fp_square_pkg::*;
#(
    parameter int WE = 8,
    parameter int WF = 23
);
    localparam int FW = fp_width(WE, WF);

    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_x;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_r;
    logic          out_ovf;
    logic          out_unf;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_r, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_r, out_ovf, out_unf
    );

endinterface

// File: rtl/int_squarer_pipe.sv
// Registered unsigned squarer with load enable. Kept as its own block so a
// DSP-tiled multiplier can be dropped in without touching the pipeline.
module int_squarer_pipe #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           en,
    input  logic [W-1:0]   a,
    output logic [2*W-1:0] p
);
    logic [2*W-1:0] p_d;
    logic [2*W-1:0] p_q;

    // Next product: load a*a when enabled, otherwise hold.
    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = {{W{1'b0}}, a} * {{W{1'b0}}, a};
        end
    end

    // Product register (data only, no reset).
    always_ff @(posedge clk) begin
        p_q <= p_d;
    end

    assign p = p_q;

endmodule

// File: rtl/fp_square_pipe.sv
// Three-stage pipelined floating-point squarer x*x for the
// {exc, sign, exp, frac} format, with valid/ready flow control and
// per-result overflow/underflow flags. A stall freezes every stage.
module fp_square_pipe
    import fp_square_pkg::*;
#(
    parameter int WE = 8,
    parameter int WF = 23
) (
    input  logic            clk,
    input  logic            rst,
    fp_square_pipe_if.slave bus
);
    localparam int FW = fp_width(WE, WF);
    localparam int MW = WF + 1;
    localparam int PW = 2 * MW;
    localparam int XW = WE + 2;
    localparam int RW = XW + WF;
    localparam logic signed [XW-1:0] BIAS = XW'(bias(WE));

    // Round to nearest, ties to even.
    function automatic logic rne_cin(input logic guard, input logic sticky, input logic ulp);
        return guard & (sticky | ulp);
    endfunction

    // Saturate finite results on the top two bits of the rounded exponent:
    // 00 in range, 01 too large (inf), 1x negative (flush to zero).
    function automatic exc_map_t map_exc(input exc_e exc_in, input logic [1:0] t);
        exc_map_t r;
        r.exc = exc_in;
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (exc_in == EXC_NORM) begin
            case (t)
                2'b00:   r.exc = EXC_NORM;
                2'b01: begin
                    r.exc = EXC_INF;
                    r.ovf = 1'b1;
                end
                default: begin
                    r.exc = EXC_ZERO;
                    r.unf = 1'b1;
                end
            endcase
        end
        return r;
    endfunction

    logic adv;

    logic          vld_p1_d, vld_p1_q;
    exc_e          exc_p1_d, exc_p1_q;
    logic [WE-1:0] exp_p1_d, exp_p1_q;
    logic [WF-1:0] frac_p1_d, frac_p1_q;

    logic          vld_p2_d, vld_p2_q;
    exc_e          exc_p2_d, exc_p2_q;
    logic [WE-1:0] exp_p2_d, exp_p2_q;
    logic [PW-1:0] prod_p2;

    logic                 n_p2;
    logic [PW-1:0]        pn_p2;
    logic signed [XW-1:0] e_p2;
    logic [WF-1:0]        f_p2;
    logic                 cin_p2;
    logic [RW-1:0]        sum_p2;
    exc_map_t             map_p2;

    logic          out_valid_d, out_valid_q;
    logic [FW-1:0] out_r_d, out_r_q;
    logic          out_ovf_d, out_ovf_q;
    logic          out_unf_d, out_unf_q;

    logic unused_bits;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    // ---- S1: decode operand / S2: carry exc and exp beside the product ----
    always_comb begin
        vld_p1_d  = vld_p1_q;
        exc_p1_d  = exc_p1_q;
        exp_p1_d  = exp_p1_q;
        frac_p1_d = frac_p1_q;
        vld_p2_d  = vld_p2_q;
        exc_p2_d  = exc_p2_q;
        exp_p2_d  = exp_p2_q;
        if (adv) begin
            vld_p1_d  = bus.in_valid;
            exc_p1_d  = exc_e'(bus.in_x[FW-1 -: 2]);
            exp_p1_d  = bus.in_x[WE+WF-1:WF];
            frac_p1_d = bus.in_x[WF-1:0];
            vld_p2_d  = vld_p1_q;
            exc_p2_d  = exc_p1_q;
            exp_p2_d  = exp_p1_q;
        end
    end

    // Stage valids: the only stage state that needs clearing on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    // Stage data registers, no reset (qualified by the stage valids).
    always_ff @(posedge clk) begin
        exc_p1_q  <= exc_p1_d;
        exp_p1_q  <= exp_p1_d;
        frac_p1_q <= frac_p1_d;
        exc_p2_q  <= exc_p2_d;
        exp_p2_q  <= exp_p2_d;
    end

    // ---- S2: (WF+1)^2 mantissa product ----
    int_squarer_pipe #(
        .W (MW)
    ) u_sq (
        .clk (clk),
        .en  (adv),
        .a   ({1'b1, frac_p1_q}),
        .p   (prod_p2)
    );

    // ---- S3: normalise, round, map exceptions ----
    always_comb begin
        n_p2   = prod_p2[PW-1];
        pn_p2  = n_p2 ? prod_p2 : (prod_p2 << 1);
        e_p2   = $signed({1'b0, exp_p2_q, 1'b0}) - BIAS + $signed(XW'(n_p2));
        f_p2   = pn_p2[PW-2 -: WF];
        cin_p2 = rne_cin(pn_p2[WF], |pn_p2[WF-1:0], pn_p2[WF+1]);
        // A mantissa carry out of F ripples straight into the exponent.
        sum_p2 = {e_p2, f_p2} + RW'(cin_p2);
        map_p2 = map_exc(exc_p2_q, sum_p2[RW-1 -: 2]);

        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;
        if (adv) begin
            out_valid_d = vld_p2_q;
            out_r_d     = {map_p2.exc, 1'b0, sum_p2[RW-3:0]};
            out_ovf_d   = map_p2.ovf;
            out_unf_d   = map_p2.unf;
        end
    end

    // Output registers: cleared on reset so nothing stale leaves the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_unf   = out_unf_q;

    // Input sign never matters for a square; the pre-shift MSB is always
    // consumed through n_p2.
    assign unused_bits = ^{bus.in_x[WE+WF], pn_p2[PW-1]};

endmodule
